// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude converter pipeline.
// Holds the direction encoding, the two's-complement minimum helper,
// the default lane geometry and a saturating adder used by the
// optional event counters (SM_CONVERT_EVENT_CNT_EN).
package sm_pkg;

    localparam int SM_DEFAULT_DW    = 9;
    localparam int SM_DEFAULT_LANES = 4;
    localparam int SM_MAX_DW        = 64;
    localparam int SM_CNT_W         = 32;

    // Conversion direction, one per transaction.
    typedef enum logic {
        DIR_TC2SM = 1'b0,   // two's complement -> sign-magnitude
        DIR_SM2TC = 1'b1    // sign-magnitude -> two's complement
    } dir_e;

    // Two's-complement minimum (-2^(dw-1)) as a bit pattern, LSB-aligned.
    // Callers truncate the result to their own word width.
    function automatic logic [SM_MAX_DW-1:0] sm_min(input int dw);
        logic [SM_MAX_DW-1:0] v;
        v         = '0;
        v[dw-1]   = 1'b1;
        return v;
    endfunction

    // Unsigned add that sticks at all-ones instead of wrapping.
    function automatic logic [SM_CNT_W-1:0] sat_add(
        input logic [SM_CNT_W-1:0] a,
        input logic [SM_CNT_W-1:0] b
    );
        logic [SM_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SM_CNT_W] ? '1 : sum[SM_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sm_lane_conv.sv
// Single-lane combinational converter between two's complement and
// sign-magnitude. Flags saturation of the two's-complement minimum
// (which has no sign-magnitude encoding) and normalisation of
// sign-magnitude negative zero.
module sm_lane_conv
    import sm_pkg::*;
#(
    parameter int DW = SM_DEFAULT_DW
) (
    input  logic [DW-1:0] in,
    input  dir_e          dir,
    output logic [DW-1:0] out,
    output logic          sat,
    output logic          negz
);

    localparam logic [DW-1:0] MIN_VAL = DW'(sm_min(DW));

    logic          sign;
    logic [DW-2:0] mag;
    logic [DW-1:0] tc_neg;   // -in, magnitude of a negative two's-complement word
    logic [DW-1:0] sm_neg;   // -{0,mag}, two's-complement form of a negative SM word

    assign sign   = in[DW-1];
    assign mag    = in[DW-2:0];
    assign tc_neg = -in;
    assign sm_neg = -{1'b0, mag};

    // Select the converted word and flags for the requested direction.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // branches below leaves one unassigned and infers a latch.
        out  = in;
        sat  = 1'b0;
        negz = 1'b0;
        if (dir == DIR_TC2SM) begin
            if (sign) begin
                if (in == MIN_VAL) begin
                    out = '1;               // clamp to -(2^(DW-1)-1)
                    sat = 1'b1;
                end else begin
                    out = {1'b1, tc_neg[DW-2:0]};
                end
            end
        end else begin
            if (sign) begin
                if (mag == '0) begin
                    out  = '0;              // -0 becomes the single zero
                    negz = 1'b1;
                end else begin
                    out = sm_neg;
                end
            end
        end
    end

endmodule

// File: rtl/sm_convert_pipe.sv
// Multi-lane, two-stage pipelined converter between two's complement
// and sign-magnitude with a valid/ready handshake on both sides.
// S1 holds the raw lanes and direction; the lane converters sit between
// S1 and S2; out_* are driven straight from S2.
// Optional feature macro: SM_CONVERT_EVENT_CNT_EN adds clr_cnt, sat_cnt
// and negz_cnt event counters.
module sm_convert_pipe
    import sm_pkg::*;
#(
    parameter int DW    = SM_DEFAULT_DW,
    parameter int LANES = SM_DEFAULT_LANES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_dir,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic [LANES-1:0]      out_sat,
    output logic [LANES-1:0]      out_negz
`ifdef SM_CONVERT_EVENT_CNT_EN
    ,
    input  logic                  clr_cnt,
    output logic [SM_CNT_W-1:0]   sat_cnt,
    output logic [SM_CNT_W-1:0]   negz_cnt
`endif
);

    // Stage 1: raw operands.
    logic                s1_valid;
    dir_e                s1_dir;
    logic [LANES*DW-1:0] s1_data;

    // Converter outputs (combinational from S1).
    logic [LANES*DW-1:0] conv_data;
    logic [LANES-1:0]    conv_sat;
    logic [LANES-1:0]    conv_negz;

    // Stage 2: results.
    logic                s2_valid;
    logic [LANES*DW-1:0] s2_data;
    logic [LANES-1:0]    s2_sat;
    logic [LANES-1:0]    s2_negz;

    logic s2_adv;
    logic s1_adv;

    // Each stage moves when its consumer takes data or it holds nothing.
    // in_ready is therefore combinational from out_ready (no skid buffer).
    assign s2_adv   = out_ready | ~s2_valid;
    assign s1_adv   = s2_adv | ~s1_valid;
    assign in_ready = s1_adv;

    // S1 occupancy: load on acceptance, empty when its contents move on.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // flop samples the pre-edge value of the others.
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    // S1 payload capture on an accepted input.
    always_ff @(posedge clk) begin
        // NOTE: the payload is only ever observed behind s1_valid, so it
        // needs no reset and stays a plain enabled register.
        if (s1_adv && in_valid) begin
            s1_data <= in_data;
            s1_dir  <= dir_e'(in_dir);
        end
    end

    // Lane converters between S1 and S2; all lanes share S1's direction.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sm_lane_conv #(
            .DW (DW)
        ) u_conv (
            .in   (s1_data[i*DW +: DW]),
            .dir  (s1_dir),
            .out  (conv_data[i*DW +: DW]),
            .sat  (conv_sat[i]),
            .negz (conv_negz[i])
        );
    end

    // S2 result register; holds while the downstream stalls it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= '0;
            s2_negz  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= conv_data;
                s2_sat  <= conv_sat;
                s2_negz <= conv_negz;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_sat   = s2_sat;
    assign out_negz  = s2_negz;

`ifdef SM_CONVERT_EVENT_CNT_EN
    logic                out_xfer;
    logic [SM_CNT_W-1:0] sat_pop;
    logic [SM_CNT_W-1:0] negz_pop;

    assign out_xfer = s2_valid & out_ready;
    assign sat_pop  = SM_CNT_W'($countones(s2_sat));
    assign negz_pop = SM_CNT_W'($countones(s2_negz));

    // Event counters: clear wins over a same-cycle increment; no wrap.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            sat_cnt  <= '0;
            negz_cnt <= '0;
        end else if (out_xfer) begin
            sat_cnt  <= sat_add(sat_cnt, sat_pop);
            negz_cnt <= sat_add(negz_cnt, negz_pop);
        end
    end
`endif

endmodule

// File: tb/tb_sm_convert_pipe.sv
// Self-checking bench for sm_convert_pipe (DW=9, LANES=4).
// Expected results come from an arithmetic reference model and sit in a
// scoreboard queue from acceptance until the DUT delivers them.
// Counter tests are compiled when SM_CONVERT_EVENT_CNT_EN is defined.
`timescale 1ns/1ps
module tb_sm_convert_pipe;

    localparam int DW    = 9;
    localparam int LANES = 4;
    localparam int LW    = DW * LANES;

    typedef struct packed {
        logic [LW-1:0]    data;
        logic [LANES-1:0] sat;
        logic [LANES-1:0] negz;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_dir;
    logic [LW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    out_data;
    logic [LANES-1:0] out_sat;
    logic [LANES-1:0] out_negz;
`ifdef SM_CONVERT_EVENT_CNT_EN
    logic             clr_cnt;
    logic [31:0]      sat_cnt;
    logic [31:0]      negz_cnt;
`endif

    sm_convert_pipe #(
        .DW    (DW),
        .LANES (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dir    (in_dir),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_negz  (out_negz)
`ifdef SM_CONVERT_EVENT_CNT_EN
        ,
        .clr_cnt   (clr_cnt),
        .sat_cnt   (sat_cnt),
        .negz_cnt  (negz_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    exp_t          sb[$];
    logic [LW-1:0] cap_q[$];
    bit            cap_en = 1'b0;
    logic          last_acc;
    logic          last_stall;
    logic [LW-1:0] last_held;

    // Reference model built from integer arithmetic on each lane.
    function automatic exp_t model(input logic dir, input logic [LW-1:0] d);
        exp_t e;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [DW-1:0] x;
            logic [DW-1:0] o;
            int            v;
            int            m;
            x = d[i*DW +: DW];
            v = int'(x) - (x[DW-1] ? (1 << DW) : 0);
            m = int'(x[DW-2:0]);
            if (!dir) begin
                if (v >= 0) o = x;
                else if (v == -(1 << (DW-1))) begin
                    o = DW'((1 << DW) - 1);
                    e.sat[i] = 1'b1;
                end else o = DW'((1 << (DW-1)) + (-v));
            end else begin
                if (!x[DW-1]) o = x;
                else if (m == 0) begin
                    o = '0;
                    e.negz[i] = 1'b1;
                end else o = DW'((1 << DW) - m);
            end
            e.data[i*DW +: DW] = o;
        end
        return e;
    endfunction

    // One clock: sample mid-cycle (scoreboard push/pop), then step past the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc   = !rst && in_valid && in_ready;
        last_stall = out_valid && !out_ready;
        last_held  = out_data;
        if (!rst && in_valid && in_ready) sb.push_back(model(in_dir, in_data));
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_extra got data=%h sat=%b negz=%b, expected no output",
                         out_data, out_sat, out_negz);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_sat !== e.sat || out_negz !== e.negz) begin
                    failures++;
                    $display("FAIL sb_data got data=%h sat=%b negz=%b, expected data=%h sat=%b negz=%b",
                             out_data, out_sat, out_negz, e.data, e.sat, e.negz);
                end
            end
            if (cap_en) cap_q.push_back(out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic dir, input logic [LW-1:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_dir   = dir;
        in_data  = d;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 50);
        checks++;
        if (!last_acc) begin
            failures++;
            $display("FAIL send_timeout in_ready never high in %0d cycles", n);
        end
    endtask

    task automatic wait_drain();
        int n;
        n        = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_dir    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, out_data, out_sat, out_negz, in_ready} !== {1'b0, {LW{1'b0}}, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got valid=%b data=%h sat=%b negz=%b ready=%b, expected 0/0/0/0/1",
                     out_valid, out_data, out_sat, out_negz, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_tc2sm();
        out_ready = 1'b1;
        send(1'b0, {9'h000, 9'h100, 9'h1FF, 9'h005});
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL tc2sm_latency1 got out_valid=%b expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {9'h000, 9'h1FF, 9'h101, 9'h005} ||
            out_sat !== 4'b0100 || out_negz !== 4'b0000) begin
            failures++;
            $display("FAIL tc2sm_vec got valid=%b data=%h sat=%b negz=%b, expected 1 %h 0100 0000",
                     out_valid, out_data, out_sat, out_negz, {9'h000, 9'h1FF, 9'h101, 9'h005});
        end
        wait_drain();
    endtask

    task automatic test_sm2tc();
        out_ready = 1'b1;
        send(1'b1, {9'h1FF, 9'h0FF, 9'h100, 9'h101});
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {9'h101, 9'h0FF, 9'h000, 9'h1FF} ||
            out_sat !== 4'b0000 || out_negz !== 4'b0010) begin
            failures++;
            $display("FAIL sm2tc_vec got valid=%b data=%h sat=%b negz=%b, expected 1 %h 0000 0010",
                     out_valid, out_data, out_sat, out_negz, {9'h101, 9'h0FF, 9'h000, 9'h1FF});
        end
        wait_drain();
    endtask

    // Alternating directions at full rate: every cycle must accept.
    task automatic test_back_to_back();
        int n;
        n         = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_dir  = k[0];
            in_data = LW'({$urandom(), $urandom()});
            tick();
            if (last_acc) n++;
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL back_to_back accepted=%0d expected 8", n);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] d[6];
        int            sent;
        bit            saw_block;
        sent      = 0;
        saw_block = 1'b0;
        for (int k = 0; k < 6; k++) d[k] = LW'({$urandom(), $urandom()});
        for (int c = 0; c < 60 && (sent < 6 || sb.size() > 0); c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 6) begin
                in_valid = 1'b1;
                in_dir   = sent[0];
                in_data  = d[sent];
            end else begin
                in_valid = 1'b0;
            end
            if (!in_ready) saw_block = 1'b1;
            tick();
            if (last_acc) sent++;
            if (last_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== last_held) begin
                    failures++;
                    $display("FAIL bp_hold got valid=%b data=%h expected 1 %h",
                             out_valid, out_data, last_held);
                end
            end
        end
        checks++;
        if (!saw_block || sent != 6 || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_summary got blocked=%0d sent=%0d pending=%0d expected 1 6 0",
                     saw_block, sent, sb.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic test_round_trip();
        logic [LW-1:0] p1[128];
        logic [LW-1:0] d;
        logic [LW-1:0] want;
        logic [DW-1:0] orig;
        out_ready = 1'b1;
        cap_en    = 1'b1;
        cap_q.delete();
        for (int k = 0; k < 128; k++) begin
            for (int i = 0; i < LANES; i++) d[i*DW +: DW] = DW'(4*k + i);
            send(1'b0, d);
        end
        wait_drain();
        checks++;
        if (cap_q.size() != 128) begin
            failures++;
            $display("FAIL rt_pass1_count got %0d expected 128", cap_q.size());
        end
        for (int k = 0; k < 128; k++) p1[k] = (k < cap_q.size()) ? cap_q[k] : '0;
        cap_q.delete();
        for (int k = 0; k < 128; k++) send(1'b1, p1[k]);
        wait_drain();
        cap_en = 1'b0;
        for (int k = 0; k < 128; k++) begin
            for (int i = 0; i < LANES; i++) begin
                orig = DW'(4*k + i);
                want[i*DW +: DW] = (orig == 9'h100) ? 9'h101 : orig;
            end
            checks++;
            if (k >= cap_q.size() || cap_q[k] !== want) begin
                failures++;
                $display("FAIL round_trip txn=%0d got %h expected %h",
                         k, (k < cap_q.size()) ? cap_q[k] : {LW{1'bx}}, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(1'b0, {9'h100, 9'h0AA, 9'h1F0, 9'h001});
        send(1'b1, {9'h100, 9'h155, 9'h00F, 9'h181});
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_full got ready=%b valid=%b expected 0 1", in_ready, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("FAIL rm_after got valid=%b ready=%b data=%h expected 0 1 0",
                     out_valid, in_ready, out_data);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rm_stale cycle=%0d got out_valid=%b expected 0", c, out_valid);
            end
        end
    endtask

`ifdef SM_CONVERT_EVENT_CNT_EN
    task automatic test_counters();
        int n;
        out_ready = 1'b1;
        clr_cnt   = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (sat_cnt !== 32'd0 || negz_cnt !== 32'd0) begin
            failures++;
            $display("FAIL cnt_clear got sat=%0d negz=%0d expected 0 0", sat_cnt, negz_cnt);
        end
        for (int k = 0; k < 3; k++) send(1'b0, {9'h100, 9'h005, 9'h100, 9'h000});
        wait_drain();
        checks++;
        if (sat_cnt !== 32'd6 || negz_cnt !== 32'd0) begin
            failures++;
            $display("FAIL cnt_sat got sat=%0d negz=%0d expected 6 0", sat_cnt, negz_cnt);
        end
        send(1'b1, {9'h100, 9'h100, 9'h001, 9'h005});
        wait_drain();
        checks++;
        if (sat_cnt !== 32'd6 || negz_cnt !== 32'd2) begin
            failures++;
            $display("FAIL cnt_negz got sat=%0d negz=%0d expected 6 2", sat_cnt, negz_cnt);
        end
        out_ready = 1'b0;
        send(1'b0, {9'h100, 9'h100, 9'h100, 9'h000});
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        clr_cnt   = 1'b1;
        out_ready = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (sat_cnt !== 32'd0 || negz_cnt !== 32'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL cnt_clr_prio got sat=%0d negz=%0d pending=%0d expected 0 0 0",
                     sat_cnt, negz_cnt, sb.size());
        end
    endtask
`endif

    initial begin
`ifdef SM_CONVERT_EVENT_CNT_EN
        clr_cnt = 1'b0;
`endif
        test_reset();
        test_tc2sm();
        test_sm2tc();
        test_back_to_back();
        test_backpressure();
        test_round_trip();
        test_reset_mid();
`ifdef SM_CONVERT_EVENT_CNT_EN
        test_counters();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
